// File: rtl/ling_pkg.sv
// Shared constants and the stage-1 state record for the sparse-4 Ling pipelines.
package ling_pkg;

  localparam int LING_W       = 32;
  localparam int LING_GROUP   = 4;
  localparam int LING_NGROUPS = LING_W / LING_GROUP;

  // h2/pr2 hold one 4-span Ling term per group, taken at the group's top bit
  typedef struct packed {
    logic [LING_NGROUPS-1:0] h2;
    logic [LING_NGROUPS-1:0] pr2;
    logic [LING_W-1:0]       x;
    logic [LING_W-1:0]       g;
    logic [LING_W-1:0]       p;
    logic                    sa;
    logic                    sb;
  } s1_state_t;

endpackage

// File: rtl/ling_sparse4_sum.sv
// Second-stage Ling logic: group carries from the 4-span terms, then 4-bit Ling sums.
module ling_sparse4_sum
  import ling_pkg::*;
(
  input  s1_state_t         s1,
  output logic [LING_W-1:0] diff,
  output logic              c32
);

  logic [LING_NGROUPS-1:0] h3;
  logic                    hprev;
  logic                    unused_signs;

  // Carry-in is already folded into bit 0, so nothing enters below group 0
  always_comb begin
    h3    = '0;
    hprev = 1'b0;
    for (int k = 0; k < LING_NGROUPS; k++) begin
      h3[k] = s1.h2[k] | (s1.pr2[k] & hprev);
      hprev = h3[k];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LING_NGROUPS; gi++) begin : g_grp
      localparam int B = gi * LING_GROUP;
      logic cin_grp;
      logic hb0, hb1, hb2;

      if (gi == 0) begin : g_lsb
        assign cin_grp = 1'b0;
        assign hb0     = s1.g[B];
      end else begin : g_mid
        assign cin_grp = h3[gi-1] & s1.p[B-1];
        assign hb0     = s1.g[B] | (s1.p[B-1] & h3[gi-1]);
      end

      assign hb1 = s1.g[B+1] | (s1.p[B]   & hb0);
      assign hb2 = s1.g[B+2] | (s1.p[B+1] & hb1);

      assign diff[B]   = s1.x[B]   ^ cin_grp;
      assign diff[B+1] = s1.x[B+1] ^ (hb0 & s1.p[B]);
      assign diff[B+2] = s1.x[B+2] ^ (hb1 & s1.p[B+1]);
      assign diff[B+3] = s1.x[B+3] ^ (hb2 & s1.p[B+2]);
    end
  endgenerate

  assign c32 = h3[LING_NGROUPS-1] & s1.p[LING_W-1];

  // Sign bits travel with the state for the flag logic in the enclosing pipeline
  assign unused_signs = s1.sa ^ s1.sb;

endmodule

// File: rtl/l32_ling_sub_pipe.sv
// Two-stage 32-bit Ling subtractor (a - b - bin) with valid/ready on both sides and
// borrow/overflow/zero/signed-less-than flags.
module l32_ling_sub_pipe
  import ling_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic             lt_s
);

  if (WIDTH != LING_W || GROUP != LING_GROUP) begin : g_bad_param
    $error("l32_ling_sub_pipe supports only WIDTH=32, GROUP=4");
  end

  logic [LING_W-1:0]       bb, g_raw, x_raw, g_s1, p_s1, x_s1;
  logic                    cin;
  logic [LING_NGROUPS-1:0] h2_next, pr2_next;
  s1_state_t               s1_next, s1_state_reg;
  logic                    s1_valid_reg, out_valid_reg;
  logic [LING_W-1:0]       diff_reg, diff_next;
  logic                    bout_reg, ovf_reg, zero_reg, lt_s_reg;
  logic                    bout_next, ovf_next, zero_next, lt_s_next;
  logic                    c32;
  logic                    in_xfer, s2_load;

  assign bb    = ~b;
  assign cin   = ~bin;
  assign g_raw = a & bb;
  assign x_raw = a ^ bb;
  assign p_s1  = a | bb;
  // Bit 0 absorbs the carry-in: its Ling term becomes H0 = g0 | cin
  assign g_s1  = {g_raw[LING_W-1:1], g_raw[0] | cin};
  assign x_s1  = {x_raw[LING_W-1:1], x_raw[0] ^ cin};

  genvar gi;
  generate
    for (gi = 0; gi < LING_NGROUPS; gi++) begin : g_span
      localparam int B = gi * LING_GROUP;
      logic h1_hi, h1_lo, pr1_hi, pr1_lo;

      assign h1_hi  = g_s1[B+3] | (p_s1[B+2] & g_s1[B+2]);
      assign h1_lo  = g_s1[B+1] | (p_s1[B]   & g_s1[B]);
      assign pr1_hi = p_s1[B+2] & p_s1[B+1];

      if (gi == 0) begin : g_lsb
        assign pr1_lo = p_s1[B];
      end else begin : g_mid
        assign pr1_lo = p_s1[B] & p_s1[B-1];
      end

      assign h2_next[gi]  = h1_hi | (pr1_hi & h1_lo);
      assign pr2_next[gi] = pr1_hi & pr1_lo;
    end
  endgenerate

  assign s1_next = '{h2: h2_next, pr2: pr2_next, x: x_s1, g: g_s1, p: p_s1,
                     sa: a[LING_W-1], sb: b[LING_W-1]};

  ling_sparse4_sum u_sum (
    .s1   (s1_state_reg),
    .diff (diff_next),
    .c32  (c32)
  );

  assign bout_next = ~c32;
  assign ovf_next  = (s1_state_reg.sa ^ s1_state_reg.sb) & (diff_next[LING_W-1] ^ s1_state_reg.sa);
  assign zero_next = ~|diff_next;
  assign lt_s_next = diff_next[LING_W-1] ^ ovf_next;

  assign s2_load  = s1_valid_reg & (~out_valid_reg | out_ready);
  assign in_ready = ~rst & (~s1_valid_reg | s2_load);
  assign in_xfer  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_state_reg  <= '0;
      s1_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      diff_reg      <= '0;
      bout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      zero_reg      <= 1'b0;
      lt_s_reg      <= 1'b0;
    end else begin
      if (in_xfer) begin
        s1_state_reg <= s1_next;
        s1_valid_reg <= 1'b1;
      end else if (s2_load) begin
        s1_valid_reg <= 1'b0;
      end

      if (s2_load) begin
        out_valid_reg <= 1'b1;
        diff_reg      <= diff_next;
        bout_reg      <= bout_next;
        ovf_reg       <= ovf_next;
        zero_reg      <= zero_next;
        lt_s_reg      <= lt_s_next;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign diff      = diff_reg;
  assign bout      = bout_reg;
  assign ovf       = ovf_reg;
  assign zero      = zero_reg;
  assign lt_s      = lt_s_reg;

endmodule

// File: tb/tb_l32_ling_sub_pipe.sv
// Scoreboard bench for l32_ling_sub_pipe: directed vectors, backpressure, reset, random soak.
module tb_l32_ling_sub_pipe;

  typedef struct packed {
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
    logic        lt_s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout, ovf, zero, lt_s;

  logic        dir_rdy;
  logic        rand_rdy;
  logic        rand_mode;
  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  int          idx;
  int          nout  = 0;

  always #5 clk = ~clk;

  assign out_ready = rand_mode ? rand_rdy : dir_rdy;

  l32_ling_sub_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero),
    .lt_s      (lt_s)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic bo, input logic ov,
                              input logic ze, input logic lt);
    exp_t e;
    e.diff = d; e.bout = bo; e.ovf = ov; e.zero = ze; e.lt_s = lt;
    return e;
  endfunction

  // Independent reference: 33-bit unsigned for borrow, 34-bit signed for overflow/compare
  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb, input logic tbin);
    logic [32:0] w;
    logic [33:0] s;
    exp_t        e;
    w = {1'b0, ta} - {1'b0, tb} - {32'd0, tbin};
    s = {ta[31], ta[31], ta} - {tb[31], tb[31], tb} - {33'd0, tbin};
    e.diff = w[31:0];
    e.bout = w[32];
    e.zero = (w[31:0] == 32'd0);
    e.lt_s = s[33];
    e.ovf  = (s[33:31] != 3'b000) && (s[33:31] != 3'b111);
    return e;
  endfunction

  // Returns at the negedge before the transfer edge; the beat is pushed only when accepted.
  task automatic send_exp(input logic [31:0] ta, input logic [31:0] tb, input logic tbin,
                          input exp_t e);
    int waitc = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; a = ta; b = tb; bin = tbin;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waitc++;
      if (waitc > 1000) begin
        chk("send_timeout", 64'(in_ready), 64'(1));
        return;
      end
      @(posedge clk); #1;
    end
    sb.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got diff=%h required no output", diff);
      end else begin
        mon_e = sb.pop_front();
        nout++;
        $display("out %0d: diff=%h bout=%b ovf=%b zero=%b lt_s=%b", nout, diff, bout, ovf, zero, lt_s);
        chk("diff", 64'(diff), 64'(mon_e.diff));
        chk("bout", 64'(bout), 64'(mon_e.bout));
        chk("ovf",  64'(ovf),  64'(mon_e.ovf));
        chk("zero", 64'(zero), 64'(mon_e.zero));
        chk("lt_s", 64'(lt_s), 64'(mon_e.lt_s));
      end
    end
  end

  initial begin
    rand_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      rand_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rbin;
    int          waitc;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0;
    dir_rdy = 1'b1; rand_mode = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready_after", 64'(in_ready), 64'(1));
    chk("rst_flags", 64'({diff, bout, ovf, zero, lt_s}), 64'(0));

    // Latency on an empty pipeline with out_ready held high
    send_exp(32'h0000_0005, 32'h0000_000F, 1'b0, mk(32'hFFFF_FFF6, 1, 0, 0, 1));
    idle();
    @(negedge clk);
    chk("lat_cycle1", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("lat_cycle2", 64'(out_valid), 64'(1));

    send_exp(32'h8000_0000, 32'h0000_0001, 1'b0, mk(32'h7FFF_FFFF, 0, 1, 0, 1));
    send_exp(32'h1234_5678, 32'h1234_5678, 1'b0, mk(32'h0000_0000, 0, 0, 1, 0));
    send_exp(32'h0000_0000, 32'h0000_0000, 1'b1, mk(32'hFFFF_FFFF, 1, 0, 0, 1));
    send_exp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, mk(32'hFFFF_FFFF, 1, 0, 0, 1));
    send_exp(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, mk(32'h8000_0000, 1, 1, 0, 0));
    send_exp(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, mk(32'h0000_0000, 0, 1, 1, 1));
    idle();
    repeat (4) @(negedge clk);

    // Backpressure: stall six cycles while offering beats 10..14 - 3
    idx = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(posedge clk); #1;
      dir_rdy = 1'b0;
      in_valid = 1'b1; a = 32'(10 + idx); b = 32'd3; bin = 1'b0;
      @(negedge clk);
      if (cyc >= 2) begin
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_out_valid", 64'(out_valid), 64'(1));
        chk("bp_hold_diff", 64'(diff), 64'(7));
      end
      if (in_ready) begin
        sb.push_back(mk(32'(7 + idx), 0, 0, 0, 0));
        idx++;
      end
    end
    chk("bp_accepted", 64'(idx), 64'(2));
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(posedge clk); #1;
      dir_rdy = 1'b1;
      if (idx < 5) begin
        in_valid = 1'b1; a = 32'(10 + idx);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_no_gap", 64'(out_valid), 64'(1));
      if (in_valid && in_ready) begin
        sb.push_back(mk(32'(7 + idx), 0, 0, 0, 0));
        idx++;
      end
    end
    idle();
    repeat (3) @(negedge clk);

    // Reset with two beats in flight; neither may ever emerge
    dir_rdy = 1'b0;
    send_exp(32'd100, 32'd1, 1'b0, model(32'd100, 32'd1, 1'b0));
    send_exp(32'd200, 32'd2, 1'b0, model(32'd200, 32'd2, 1'b0));
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", 64'(in_ready), 64'(0));
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    dir_rdy = 1'b1;
    @(negedge clk);
    chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
    chk("rst_mid_in_ready_after", 64'(in_ready), 64'(1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_stale", 64'(out_valid), 64'(0));
    end

    // Random soak with random out_ready stalls
    rand_mode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      ra   = $urandom;
      rb   = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      rbin = 1'($urandom_range(0, 1));
      send_exp(ra, rb, rbin, model(ra, rb, rbin));
    end
    idle();
    rand_mode = 1'b0;
    waitc = 0;
    while (sb.size() != 0 && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    chk("drain_empty", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l32_ling_sub_pipe.md
Name: l32_ling_sub_pipe

Overview:
- 32-bit subtractor built on the sparse-4 Ling carry tree, computing diff = a - b - bin.
- Implemented as a + ~b + ~bin, with the carry-in injected at bit 0.
- Two register stages with valid/ready handshakes on both ends; sustains one operation per cycle.
- Counterpart to the team's combinational Ling adders. Feeds compare/branch and address-decrement paths that need flags.

Parameters:
- WIDTH, 32: operand width. Only 32 is supported; elaboration fails for any other value.
- GROUP, 4: sparse-tree group size. Fixed at 4 to match the 4-bit Ling sum blocks.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit can accept a beat this cycle
- a  in  32  minuend
- b  in  32  subtrahend
- bin  in  1  borrow-in, for chaining wider subtracts
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- diff  out  32  a - b - bin, modulo 2^32
- bout  out  1  borrow-out: 1 when unsigned a < b + bin
- ovf  out  1  signed overflow: a[31] != b[31] and diff[31] != a[31]
- zero  out  1  diff == 0
- lt_s  out  1  signed a < b + bin; equals diff[31] XOR ovf

Behaviour:
- Reset (synchronous, active-high) clears out_valid, diff, bout, ovf, zero, lt_s and both stage-valid bits to 0.
  - in_ready is 0 during the reset cycle and 1 on the first cycle after.
  - Reset mid-operation discards all in-flight beats; nothing is emitted for them.
- Input transfer happens on in_valid & in_ready. Output transfer happens on out_valid & out_ready.
- Stage S1, registered on input transfer:
  - Complement b; set cin = ~bin.
  - Form per-bit g, p, x.
  - Inject cin as g[-1] = cin, p[-1] = 1, so bit 0's predecessor propagate is 1 and H0 includes cin.
  - Compute H1/Pr1 pair terms and H2/Pr2 4-span terms.
  - Register H2, Pr2, x, g, p and a[31], b[31].
- Stage S2, output register:
  - Compute H3 group carries from S1 state.
  - Form the 4-bit Ling sums: sum_i = x_i XOR (H_{i-1} & p_{i-1}).
  - Compute carry-out c32 = H3[31] & p[31].
  - Derive bout = ~c32, then ovf, zero and lt_s from diff and the captured sign bits.
- Latency: exactly 2 cycles from input transfer to out_valid when out_ready is held high. Throughput is 1 beat per cycle.
- Pipeline advance rules:
  - S2 loads when s1_valid and (~out_valid or out_ready).
  - S1 loads on input transfer.
  - in_ready = ~s1_valid | s2_load. This is combinational from out_ready; there is no skid buffer.
- Full pipeline (both stages valid, out_ready = 0): in_ready = 0 and all registers hold. Outputs must stay stable while out_valid & ~out_ready.
- Simultaneous accept and emit in the same cycle is legal; both stages shift with no bubble.
- Empty pipeline: out_valid = 0. diff and flags hold their last values and are don't-care to consumers.
- Wrap-around: results are modulo 2^32, with no saturation.
- Beats leave in the order they were accepted.

Decomposition:
- Shared package ling_pkg holds:
  - constants LING_W = 32, LING_GROUP = 4, LING_NGROUPS = 8;
  - a packed struct s1_state_t with fields h2[7:0], pr2[7:0], x, g, p, sa, sb.
- One sub-module, ling_sparse4_sum: combinational S2 logic.
  - Inputs: s1_state_t.
  - Outputs: diff and c32.
  - Reusable later by a pipelined adder.
- Pipeline control and flag logic stay in the top module.

Test Plan:
- a=0x0000_0005, b=0x0000_000F, bin=0 -> diff=0xFFFF_FFF6, bout=1, ovf=0, zero=0, lt_s=1, out_valid exactly 2 cycles after accept.
- a=0x8000_0000, b=0x0000_0001, bin=0 -> diff=0x7FFF_FFFF, bout=0, ovf=1, lt_s=1.
- a=b=0x1234_5678, bin=0 -> diff=0, zero=1, bout=0. Then a=b=0, bin=1 -> diff=0xFFFF_FFFF, bout=1, zero=0.
- Backpressure:
  - Stimulus: present 5 back-to-back beats (a=10..14, b=3) while out_ready=0 for 6 cycles, then out_ready=1.
  - Required: only 2 beats are accepted and in_ready=0 while stalled; diff stays at 7 while stalled.
  - After release: results 7, 8, 9, 10, 11 in order with no gaps.
- Reset mid-operation: rst=1 for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, no stale result ever appears, in_ready=1 the cycle after reset.
- Random soak: 10k random a, b, bin with random out_ready stalls -> every output matches the reference model (a - b - bin, 33-bit), with no drops or duplicates.
